burst_memory: RTL and testbench

BURST_MEMORY -- requirements
Module: burst_memory

---
 rtl/burst_memory.sv | 100 ++++++++++
 tb/tb_burst_memory.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/burst_memory.sv
// burst_memory: byte-organised big-endian memory serving 1/4/8/16-word read and write bursts
module burst_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  error
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int OW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, START_ADDR} + (ADDR_WIDTH+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, aligned, ra;
    logic [4:0] cnt_q, cnt_d, len;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d, rword;
    logic valid_q, valid_d, error_q, error_d, we, ok;
    logic [ADDR_WIDTH:0] last;
    logic [OW-1:0] idx;
    logic [7:0] mem [DEPTH];

    assign aligned = address & ~ADDR_WIDTH'(BPW - 1);
    assign len = access_size == 2'd0 ? 5'd1 : 5'd2 << access_size;
    // one extra bit so a burst ending exactly at the top of the address space cannot wrap
    assign last = {1'b0, aligned} + (ADDR_WIDTH+1)'(len) * (ADDR_WIDTH+1)'(BPW);
    assign ok = aligned >= START_ADDR && last <= LIMIT;
    assign ra = state_q == IDLE ? aligned : addr_q;
    assign idx = OW'(ra - START_ADDR);

    always_comb begin
        rword = '0;
        for (int b = 0; b < BPW; b++) rword[DATA_WIDTH-1-8*b -: 8] = mem[idx + OW'(b)];
    end

    always_comb begin
        state_d = state_q;
        addr_d = addr_q + ADDR_WIDTH'(BPW);
        cnt_d = cnt_q - 5'd1;
        valid_d = 1'b0;
        error_d = 1'b0;
        we = 1'b0;
        if (state_q == IDLE) begin
            addr_d = addr_q;
            cnt_d = cnt_q;
            if (enable && !ok) error_d = 1'b1;
            else if (enable) begin
                addr_d = aligned + ADDR_WIDTH'(BPW);
                cnt_d = len - 5'd1;
                state_d = len == 5'd1 ? IDLE : rw ? RD_BURST : WR_BURST;
                we = !rw;
                valid_d = rw;
            end
        end else begin
            we = state_q == WR_BURST;
            valid_d = state_q == RD_BURST;
            state_d = cnt_q == 5'd1 ? IDLE : state_q;
        end
        data_out_d = valid_d ? rword : data_out_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            cnt_q <= '0;
            data_out_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            data_out_q <= data_out_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // storage is never reset; reset only blocks a write on the edge it overlaps
    always_ff @(posedge clock) begin
        if (we && !reset)
            for (int b = 0; b < BPW; b++) mem[idx + OW'(b)] <= data_in[DATA_WIDTH-1-8*b -: 8];
    end

    assign busy = state_q != IDLE;
    assign data_out = data_out_q;
    assign data_valid = valid_q;
    assign error = error_q;
endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: randomized bursts checked against a byte-level reference model
module tb_burst_memory;
    localparam logic [31:0] START = 32'h80020000;
    localparam int DEPTH = 1048576;
    logic clock = 1'b0, reset = 1'b1, rw = 1'b0, enable = 1'b0;
    logic [31:0] address = '0, data_in = '0, data_out;
    logic [1:0] access_size = '0;
    logic busy, data_valid, error;
    int n_checks = 0, n_fail = 0;
    logic [7:0] ref_mem [longint];
    logic [31:0] wbuf [16];
    logic [31:0] last_rd = '0, last_m = '1, hostile = '0;

    burst_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .START_ADDR(START)) dut (
        .clock(clock), .reset(reset), .address(address), .data_in(data_in),
        .access_size(access_size), .rw(rw), .enable(enable), .busy(busy),
        .data_out(data_out), .data_valid(data_valid), .error(error)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input longint a, output logic [31:0] m);
        logic [31:0] w = '0;
        m = '0;
        for (int b = 0; b < 4; b++)
            if (ref_mem.exists(a + b)) begin
                w[31-8*b -: 8] = ref_mem[a + b];
                m[31-8*b -: 8] = 8'hFF;
            end
        return w;
    endfunction

    task automatic check_hold(input string tag);
        if (last_m != 0) check(tag, data_out & last_m, last_rd & last_m);
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) begin
            @(negedge clock);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(data_valid), 32'd0);
            check("idle_error", 32'(error), 32'd0);
            check_hold("idle_hold");
        end
    endtask

    // drive one request in the current cycle and check every cycle until the next one may start
    task automatic req(input bit r, input logic [31:0] a, input logic [1:0] sz);
        int len;
        longint base;
        bit ok;
        logic [31:0] e, m;
        len = sz == 0 ? 1 : 2 << sz;
        base = longint'(a & 32'hFFFF_FFFC);
        ok = base >= longint'(START) && base + len * 4 <= longint'(START) + DEPTH;
        enable = 1'b1; rw = r; address = a; access_size = sz; data_in = wbuf[0];
        if (ok && !r)
            for (int k = 0; k < len; k++)
                for (int b = 0; b < 4; b++) ref_mem[base + 4*k + b] = wbuf[k][31-8*b -: 8];
        for (int k = 1; k <= (ok ? len : 1); k++) begin
            @(negedge clock);
            check("error", 32'(error), 32'(!ok));
            check("busy", 32'(busy), 32'(ok && k < len));
            check("valid", 32'(data_valid), 32'(ok && r));
            if (ok && r) begin
                e = exp_word(base + 4*(k-1), m);
                if (m != 0) check("rdata", data_out & m, e & m);
                last_rd = e;
                last_m = m;
            end else check_hold(r ? "hold_rd" : "hold_wr");
            if (ok && k < len) begin
                enable = hostile != 0 ? 1'b1 : 1'($urandom);
                rw = hostile != 0 ? 1'b0 : 1'($urandom);
                address = hostile != 0 ? hostile : START + $urandom_range(0, 1023);
                access_size = 2'($urandom);
                data_in = r ? $urandom : wbuf[k];
            end else enable = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        int sel;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_dout", data_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        wbuf[0] = 32'h27BDFFE8;
        req(0, START, 2'd0);
        req(1, START, 2'd0);
        check("single_rd", data_out, 32'h27BDFFE8);
        idle(1);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            req(0, START + 32'(64 * i), 2'd3);
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            req(0, START + DEPTH - 256 + 32'(64 * i), 2'd3);
        end
        for (int k = 0; k < 16; k++) wbuf[k] = 32'(k);
        req(0, START + 32'h40, 2'd3);
        req(1, START + 32'h40, 2'd3);
        check("burst16_last", data_out, 32'd15);
        req(1, START + DEPTH - 8, 2'd1);
        idle(1);
        req(1, 32'h8001FFFC, 2'd0);
        idle(1);
        req(1, START + DEPTH - 4, 2'd0);
        hostile = START + 32'h200;
        req(1, START, 2'd3);
        hostile = '0;
        req(1, START + 32'h200, 2'd0);
        wbuf[0] = 32'h11223344;
        req(0, START + 32'h4, 2'd0);
        req(1, START + 32'h6, 2'd0);
        check("byte_order", data_out, 32'h11223344);
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hC0 + 32'(k);
        req(0, START + 32'h300, 2'd2);
        enable = 1'b1; rw = 1'b0; address = START + 32'h300; access_size = 2'd2; data_in = 32'hA0;
        @(negedge clock);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        enable = 1'b0; data_in = 32'hA1;
        @(negedge clock);
        data_in = 32'hA2;
        @(negedge clock);
        data_in = 32'hA3;
        #1 reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(data_valid), 32'd0);
        check("rst_mid_dout", data_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < 4; b++) ref_mem[longint'(START) + 32'h300 + 4*k + b] = 8'(32'hA0 + k >> (24 - 8*b));
        last_rd = '0;
        last_m = '1;
        req(1, START + 32'h300, 2'd2);
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            a = sel < 7 ? START + $urandom_range(0, 1023)
              : sel < 9 ? START + DEPTH - $urandom_range(1, 256) : START - $urandom_range(1, 64);
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            req(1'($urandom), a, 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
